// File: rtl/intersection_ctrl_if.sv
// intersection_ctrl_if: mode/request inputs and light-control outputs.
// side_req exists only when SIDE_SENSE_EN is defined.
interface intersection_ctrl_if;
  logic       run;
  logic       ped_req;
`ifdef SIDE_SENSE_EN
  logic       side_req;
`endif
  logic [2:0] en;
  logic [2:0] set;
  logic [2:0] change;
  logic [2:0] green;
  logic       ped_ack;
  logic [2:0] phase;

  modport master (
`ifdef SIDE_SENSE_EN
    input  side_req,
`endif
    input  run, ped_req,
    output en, set, change, green, ped_ack, phase
  );

  modport slave (
`ifdef SIDE_SENSE_EN
    output side_req,
`endif
    output run, ped_req,
    input  en, set, change, green, ped_ack, phase
  );
endinterface

// File: rtl/intersection_ctrl.sv
// intersection_ctrl: sequences main/side/walk lights with all-red clearance.
// SIDE_SENSE_EN: side road is served only on a latched side_req.
module intersection_ctrl #(
  parameter int T_MAIN  = 20,
  parameter int T_SIDE  = 10,
  parameter int T_WALK  = 8,
  parameter int T_CLEAR = 2,
  parameter int CNT_W   = 8
) (
  input logic                 clklf,
  input logic                 reset,
  intersection_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    OFF   = 3'd0,
    START = 3'd1,
    CLR_A = 3'd2,
    MAIN  = 3'd3,
    CLR_B = 3'd4,
    WALK  = 3'd5,
    CLR_C = 3'd6,
    SIDE  = 3'd7
  } state_t;

  state_t           state, state_n, side_tgt;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             ped_pend, ped_n;
  logic             go_walk;
  logic [2:0]       en_n, change_n, green_n;
  logic             ack_n;
`ifdef SIDE_SENSE_EN
  logic             side_pend, side_n;
  logic             go_side;
`endif

  function automatic logic [CNT_W-1:0] dwell(state_t s);
    unique case (s)
      CLR_A, CLR_B, CLR_C: dwell = CNT_W'(T_CLEAR - 1);
      MAIN:                dwell = CNT_W'(T_MAIN - 1);
      WALK:                dwell = CNT_W'(T_WALK - 1);
      SIDE:                dwell = CNT_W'(T_SIDE - 1);
      default:             dwell = '0;
    endcase
  endfunction

  function automatic logic [2:0] lamp(state_t s);
    unique case (s)
      MAIN:    lamp = 3'b001;
      SIDE:    lamp = 3'b010;
      WALK:    lamp = 3'b100;
      default: lamp = 3'b000;
    endcase
  endfunction

  always_ff @(posedge clklf) begin
    if (reset) begin
      state       <= OFF;
      cnt         <= '0;
      ped_pend    <= 1'b0;
`ifdef SIDE_SENSE_EN
      side_pend   <= 1'b0;
`endif
      bus.en      <= 3'b000;
      bus.set     <= 3'b111;
      bus.change  <= 3'b000;
      bus.green   <= 3'b000;
      bus.ped_ack <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      ped_pend    <= ped_n;
`ifdef SIDE_SENSE_EN
      side_pend   <= side_n;
`endif
      bus.en      <= en_n;
      bus.set     <= 3'b111;
      bus.change  <= change_n;
      bus.green   <= green_n;
      bus.ped_ack <= ack_n;
    end
  end

  always_comb begin
`ifdef SIDE_SENSE_EN
    side_tgt = side_pend ? SIDE : CLR_A;
`else
    side_tgt = SIDE;
`endif
    state_n = state;
    cnt_n   = cnt;
    if (!bus.run) begin
      state_n = OFF;
      cnt_n   = '0;
    end else begin
      unique case (state)
        OFF:   state_n = START;
        START: state_n = CLR_A;
        CLR_A: if (cnt == '0) state_n = MAIN;
        MAIN:  if (cnt == '0) state_n = CLR_B;
        CLR_B: if (cnt == '0) state_n = ped_pend ? WALK : side_tgt;
        WALK:  if (cnt == '0) state_n = CLR_C;
        CLR_C: if (cnt == '0) state_n = side_tgt;
        SIDE:  if (cnt == '0) state_n = CLR_A;
      endcase
      if (state_n != state)
        cnt_n = dwell(state_n);
      else if (cnt != '0)
        cnt_n = cnt - CNT_W'(1);
    end

    go_walk = (state_n == WALK) && (state != WALK);
    ped_n   = ped_pend;
    if (!bus.run || go_walk)
      ped_n = 1'b0;
    else if (bus.ped_req && !(state inside {OFF, START, WALK}))
      ped_n = 1'b1;

`ifdef SIDE_SENSE_EN
    go_side = (state_n == SIDE) && (state != SIDE);
    side_n  = side_pend;
    if (!bus.run || go_side)
      side_n = 1'b0;
    else if (bus.side_req && !(state inside {OFF, START, SIDE}))
      side_n = 1'b1;
`endif
  end

  // A run drop goes dark at once: no closing change pulse.
  always_comb begin
    en_n     = (state_n == OFF) ? 3'b000 : 3'b111;
    green_n  = lamp(state_n);
    change_n = (state_n == OFF) ? 3'b000 : (lamp(state) ^ lamp(state_n));
    ack_n    = go_walk;
  end

  assign bus.phase = state;

endmodule

// File: tb/tb_intersection_ctrl.sv
// tb_intersection_ctrl: directed and random stimulus against a phase/time model.
// Define SIDE_SENSE_EN for both bench and RTL to test on-demand side service.
module tb_intersection_ctrl;
  localparam int T_MAIN  = 20;
  localparam int T_SIDE  = 10;
  localparam int T_WALK  = 8;
  localparam int T_CLEAR = 2;

  logic clklf = 1'b0;
  logic reset = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   chk_en = 0;

  intersection_ctrl_if bus ();

  intersection_ctrl #(
    .T_MAIN (T_MAIN),
    .T_SIDE (T_SIDE),
    .T_WALK (T_WALK),
    .T_CLEAR(T_CLEAR),
    .CNT_W  (8)
  ) dut (
    .clklf(clklf),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clklf = ~clklf;
  always @(posedge clklf) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d",
               nm, cyc, act, exp);
    end
  endtask

  // Behavioural model: phase id, cycles spent in it, pending requests.
  int         mph, mel;
  bit         mped, mside;
  logic [2:0] men, mchg, mgrn;
  logic       mack;

  function automatic int dur(input int p);
    case (p)
      2, 4, 6: return T_CLEAR;
      3:       return T_MAIN;
      5:       return T_WALK;
      7:       return T_SIDE;
      default: return 1;
    endcase
  endfunction

  function automatic logic [2:0] gcode(input int p);
    case (p)
      3:       return 3'b001;
      7:       return 3'b010;
      5:       return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  always @(posedge clklf) begin : model
    int         nxt;
    int         side_dst;
    logic [2:0] ng;
    if (reset || !bus.run) begin
      mph = 0; mel = 0; mped = 0; mside = 0;
      men = 3'b000; mchg = 3'b000; mgrn = 3'b000; mack = 1'b0;
    end else begin
`ifdef SIDE_SENSE_EN
      side_dst = mside ? 7 : 2;
`else
      side_dst = 7;
`endif
      if (mph == 0)                 nxt = 1;
      else if (mph == 1)            nxt = 2;
      else if (mel + 1 < dur(mph))  nxt = mph;
      else if (mph == 2)            nxt = 3;
      else if (mph == 3)            nxt = 4;
      else if (mph == 4)            nxt = mped ? 5 : side_dst;
      else if (mph == 5)            nxt = 6;
      else if (mph == 6)            nxt = side_dst;
      else                          nxt = 2;
      mack = (nxt == 5) && (mph != 5);
      if (mack) mped = 0;
      else if (bus.ped_req && !(mph inside {0, 1, 5})) mped = 1;
`ifdef SIDE_SENSE_EN
      if ((nxt == 7) && (mph != 7)) mside = 0;
      else if (bus.side_req && !(mph inside {0, 1, 7})) mside = 1;
`endif
      mel  = (nxt == mph) ? mel + 1 : 0;
      ng   = gcode(nxt);
      mchg = mgrn ^ ng;
      mgrn = ng;
      men  = 3'b111;
      mph  = nxt;
    end
  end

  always @(negedge clklf) begin
    if (chk_en) begin
      chk("en", bus.en, men);
      chk("set", bus.set, 3'b111);
      chk("change", bus.change, mchg);
      chk("green", bus.green, mgrn);
      chk("ped_ack", bus.ped_ack, mack);
      chk("phase", bus.phase, mph);
      chk("green_onehot0", $onehot0(bus.green), 1);
    end
  end

  task automatic wait_ph(input logic [2:0] p, input int budget);
    int k = 0;
    while (bus.phase !== p && k < budget) begin
      @(negedge clklf);
      k++;
    end
    chk("wait_phase", bus.phase, p);
  endtask

  task automatic stay_len(input logic [2:0] p, output int k);
    k = 0;
    while (bus.phase === p && k < 100) begin
      k++;
      @(negedge clklf);
    end
  endtask

  task automatic wait_leave(input logic [2:0] p);
    int k = 0;
    while (bus.phase === p && k < 100) begin
      @(negedge clklf);
      k++;
    end
  endtask

`ifdef SIDE_SENSE_EN
  localparam int PERIOD   = 2 + T_MAIN + 2;
  localparam int AFTER_CL = 2;
`else
  localparam int PERIOD   = 2 + T_MAIN + 2 + T_SIDE;
  localparam int AFTER_CL = 7;
`endif

  initial begin
    int len, tmain, offl;
    bus.run = 1'b0;
    bus.ped_req = 1'b0;
`ifdef SIDE_SENSE_EN
    bus.side_req = 1'b0;
`endif
    repeat (3) @(negedge clklf);
    chk_en = 1;
    chk("rst_en", bus.en, 0);
    chk("rst_set", bus.set, 7);
    chk("rst_phase", bus.phase, 0);
    reset = 1'b0;
    @(negedge clklf);
    chk("idle_phase", bus.phase, 0);
    bus.run = 1'b1;
    @(negedge clklf);
    chk("start_phase", bus.phase, 1);
    chk("start_en", bus.en, 7);
    @(negedge clklf);
    chk("clra_phase", bus.phase, 2);
    @(negedge clklf);
    chk("clra_len2", bus.phase, 2);
    @(negedge clklf);
    chk("main_entry", bus.phase, 3);
    chk("main_chg_in", bus.change, 1);
    tmain = cyc;
    stay_len(3, len);
    chk("main_len", len, T_MAIN);
    chk("main_chg_out", bus.change, 1);
    chk("main_grn_out", bus.green, 0);
`ifndef SIDE_SENSE_EN
    wait_ph(7, 10);
    chk("side_chg_in", bus.change, 2);
    stay_len(7, len);
    chk("side_len", len, T_SIDE);
    chk("side_chg_out", bus.change, 2);
`endif
    wait_ph(3, 60);
    chk("period", cyc - tmain, PERIOD);

    // pedestrian pulse during MAIN
    bus.ped_req = 1'b1;
    @(negedge clklf);
    bus.ped_req = 1'b0;
    wait_ph(5, 60);
    chk("walk_ack", bus.ped_ack, 1);
    chk("walk_chg_in", bus.change, 4);
    stay_len(5, len);
    chk("walk_len", len, T_WALK);
    chk("walk_chg_out", bus.change, 4);
    wait_leave(6);
    chk("after_clrc", bus.phase, AFTER_CL);
    wait_ph(4, 80);
    wait_leave(4);
    chk("walk_skipped", bus.phase, AFTER_CL);

    // request held through WALK entry
    wait_ph(3, 80);
    bus.ped_req = 1'b1;
    wait_ph(5, 60);
    repeat (3) @(negedge clklf);
    bus.ped_req = 1'b0;
    wait_ph(4, 80);
    wait_leave(4);
    chk("held_once", bus.phase, AFTER_CL);

    // run dropped in the fifth MAIN cycle
    wait_ph(3, 80);
    repeat (4) @(negedge clklf);
    bus.run = 1'b0;
    @(negedge clklf);
    chk("drop_phase", bus.phase, 0);
    chk("drop_en", bus.en, 0);
    chk("drop_change", bus.change, 0);
    bus.run = 1'b1;
    @(negedge clklf);
    chk("rerun_start", bus.phase, 1);

`ifdef SIDE_SENSE_EN
    bus.side_req = 1'b1;
    @(negedge clklf);
    bus.side_req = 1'b0;
    wait_ph(7, 60);
    stay_len(7, len);
    chk("side_len", len, T_SIDE);
    wait_ph(4, 80);
    wait_leave(4);
    chk("side_once", bus.phase, 2);
    bus.side_req = 1'b1;
    @(negedge clklf);
    bus.side_req = 1'b0;
`endif
    // reset during SIDE
    wait_ph(7, 80);
    repeat (3) @(negedge clklf);
    reset = 1'b1;
    @(negedge clklf);
    chk("rst_mid_phase", bus.phase, 0);
    chk("rst_mid_en", bus.en, 0);
    chk("rst_mid_green", bus.green, 0);
    reset = 1'b0;
    @(negedge clklf);
    chk("rst_restart", bus.phase, 1);

    offl = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clklf);
      if (offl > 0) begin
        offl--;
        bus.run = (offl == 0);
      end else if ($urandom_range(0, 399) == 0) begin
        offl = $urandom_range(1, 5);
        bus.run = 1'b0;
      end
      reset = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 7) == 0)
        bus.ped_req = ($urandom_range(0, 5) == 0);
`ifdef SIDE_SENSE_EN
      if ($urandom_range(0, 7) == 0)
        bus.side_req = ($urandom_range(0, 4) == 0);
`endif
    end
    @(negedge clklf);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
